// File: rtl/number_pkg.sv
// Shared definitions for the number_stepper / number_detector pair.
// Holds the num bus width, the button debounce states and the button slot map.
package number_pkg;

  localparam int NUM_WIDTH = 5;
  localparam int NUM_MAX   = 31;

  // Slot of each debounced button inside the top-level press vector
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_CLR  = 2;
  localparam int BTN_NUM  = 3;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  function automatic logic [NUM_WIDTH-1:0] num_step(input logic [NUM_WIDTH-1:0] v,
                                                     input logic up);
    return up ? v + NUM_WIDTH'(1) : v - NUM_WIDTH'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus debounce FSM for one raw pushbutton.
// Emits a single registered press pulse when a new pressed level is accepted.
module button_debounce
  import number_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_stable,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  db_state_t       r_state;
  db_state_t       w_state_next;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            r_press;
  logic            w_press_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_state <= DB_IDLE;
      r_count <= '0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_press <= w_press_next;
    end
  end

  // The count holds the cycles already spent at the new level; reaching
  // C_LAST here means this edge completes DEBOUNCE_CYCLES.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_press_next = 1'b0;
    case (r_state)
      DB_IDLE: begin
        if (r_sync) begin
          w_state_next = DB_PRESS_WAIT;
          w_count_next = CW'(1);
        end
      end
      DB_PRESS_WAIT: begin
        if (!r_sync) begin
          w_state_next = DB_IDLE;
          w_count_next = '0;
        end else if (r_count == C_LAST) begin
          w_state_next = DB_PRESSED;
          w_count_next = '0;
          w_press_next = 1'b1;
        end else begin
          w_count_next = r_count + CW'(1);
        end
      end
      DB_PRESSED: begin
        if (!r_sync) begin
          w_state_next = DB_RELEASE_WAIT;
          w_count_next = CW'(1);
        end
      end
      DB_RELEASE_WAIT: begin
        if (r_sync) begin
          w_state_next = DB_PRESSED;
          w_count_next = '0;
        end else if (r_count == C_LAST) begin
          w_state_next = DB_IDLE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + CW'(1);
        end
      end
      default: begin
        w_state_next = DB_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  assign o_stable = (r_state == DB_PRESSED) || (r_state == DB_RELEASE_WAIT);
  assign o_press  = r_press;

endmodule

// File: rtl/number_stepper.sv
// Wrapping 0..31 counter driven by debounced up/down/clear buttons and an
// optional auto-run prescaler; num feeds number_detector.num directly.
module number_stepper
  import number_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_clr,
  input  logic                 auto_en,
  output logic [NUM_WIDTH-1:0] num,
  output logic                 num_changed
);

  localparam int PW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(AUTO_PERIOD - 1);

  logic [BTN_NUM-1:0]   w_btn_raw;
  logic [BTN_NUM-1:0]   w_press;
  logic [BTN_NUM-1:0]   w_stable;
  logic                 w_unused;
  logic                 r_auto_meta;
  logic                 r_auto_sync;
  logic [PW-1:0]        r_presc;
  logic                 w_tick;
  logic [NUM_WIDTH-1:0] r_num;
  logic [NUM_WIDTH-1:0] w_num_next;
  logic                 r_changed;
  logic                 w_changed_next;

  assign w_btn_raw[BTN_UP]   = btn_up;
  assign w_btn_raw[BTN_DOWN] = btn_down;
  assign w_btn_raw[BTN_CLR]  = btn_clr;

  genvar gi;
  generate
    for (gi = 0; gi < BTN_NUM; gi++) begin : g_db
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk      (clk),
        .reset    (reset),
        .i_btn    (w_btn_raw[gi]),
        .o_stable (w_stable[gi]),
        .o_press  (w_press[gi])
      );
    end
  endgenerate

  // Debounced levels are not needed by the counter itself
  assign w_unused = &{1'b0, w_stable};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto_meta <= 1'b0;
      r_auto_sync <= 1'b0;
      r_presc     <= '0;
    end else begin
      r_auto_meta <= auto_en;
      r_auto_sync <= r_auto_meta;
      if (!r_auto_sync || r_presc == P_LAST) r_presc <= '0;
      else                                   r_presc <= r_presc + PW'(1);
    end
  end

  assign w_tick = r_auto_sync && (r_presc == P_LAST);

  // Clear beats everything; opposing presses cancel; any press swallows a tick.
  always_comb begin
    w_num_next     = r_num;
    w_changed_next = 1'b0;
    if (w_press[BTN_CLR]) begin
      w_num_next     = '0;
      w_changed_next = 1'b1;
    end else if (w_press[BTN_UP] && w_press[BTN_DOWN]) begin
      w_num_next     = r_num;
    end else if (w_press[BTN_UP]) begin
      w_num_next     = num_step(r_num, 1'b1);
      w_changed_next = 1'b1;
    end else if (w_press[BTN_DOWN]) begin
      w_num_next     = num_step(r_num, 1'b0);
      w_changed_next = 1'b1;
    end else if (w_tick) begin
      w_num_next     = num_step(r_num, 1'b1);
      w_changed_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_num     <= w_num_next;
      r_changed <= w_changed_next;
    end
  end

  assign num         = r_num;
  assign num_changed = r_changed;

endmodule

// File: tb/tb_number_stepper.sv
// Directed bench for number_stepper with a scoreboard queue of expected num
// values that a negedge monitor pops on every num_changed pulse.
module tb_number_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_clr, auto_en;
  logic [4:0] num;
  logic       num_changed;

  int         checks   = 0;
  int         failures = 0;
  logic [4:0] exp_q[$];
  bit         mon_en   = 1'b0;
  int         lat;

  always #5 clk = ~clk;

  number_stepper #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_clr    (btn_clr),
    .auto_en    (auto_en),
    .num        (num),
    .num_changed(num_changed)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every num_changed pulse must match the next queued value
  always @(negedge clk) begin
    if (mon_en && num_changed) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change: num_changed=1 num=%0d required no change", num);
      end else begin
        check("sb_num", int'(num), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic u, input logic d, input logic c);
    btn_up   = u;
    btn_down = d;
    btn_clr  = c;
  endtask

  // Full press/release of one button (0=up,1=down,2=clr), expecting value expv
  task automatic press_btn(input int which, input logic [4:0] expv);
    exp_q.push_back(expv);
    set_btns(which == 0, which == 1, which == 2);
    cycles(8);
    set_btns(1'b0, 1'b0, 1'b0);
    cycles(10);
  endtask

  // Edges until num_changed is seen; -1 if the bound expires
  task automatic wait_change(output int l, input int limit);
    l = 0;
    while (l < limit) begin
      @(negedge clk);
      l++;
      if (num_changed) return;
    end
    l = -1;
  endtask

  initial begin
    reset = 1'b1;
    set_btns(1'b0, 1'b0, 1'b0);
    auto_en = 1'b0;
    cycles(3);
    check("reset_num", int'(num), 0);
    check("reset_changed", int'(num_changed), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    cycles(20);
    check("idle_num", int'(num), 0);

    // Held button: one step after DEBOUNCE+3 edges, no repeat
    exp_q.push_back(5'd1);
    btn_up = 1'b1;
    wait_change(lat, 20);
    check("up_latency", lat, 7);
    cycles(13);
    btn_up = 1'b0;
    cycles(10);
    check("held_num", int'(num), 1);
    press_btn(0, 5'd2);

    // 3-cycle glitch is rejected
    btn_up = 1'b1;
    cycles(3);
    btn_up = 1'b0;
    cycles(12);
    check("glitch_num", int'(num), 2);

    // Wrap both ways
    press_btn(1, 5'd1);
    press_btn(1, 5'd0);
    press_btn(1, 5'd31);
    check("wrap_down", int'(num), 31);
    press_btn(0, 5'd0);
    check("wrap_up", int'(num), 0);

    // Opposing presses in the same cycle cancel
    set_btns(1'b1, 1'b1, 1'b0);
    cycles(8);
    set_btns(1'b0, 1'b0, 1'b0);
    cycles(10);
    check("simul_num", int'(num), 0);

    // Clear at 0 still pulses; clear from 5
    press_btn(2, 5'd0);
    for (int i = 1; i <= 5; i++) press_btn(0, 5'(i));
    press_btn(2, 5'd0);
    check("clr_num", int'(num), 0);

    press_btn(1, 5'd31);
    press_btn(1, 5'd30);

    // Auto run 30 -> 31 -> 0 -> 1
    exp_q.push_back(5'd31);
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    auto_en = 1'b1;
    wait_change(lat, 30);
    check("auto_first", lat, 10);
    wait_change(lat, 30);
    check("auto_period", lat, 8);
    wait_change(lat, 30);
    check("auto_period2", lat, 8);

    // Down press lands on the next tick edge: tick dropped
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    cycles(1);
    btn_down = 1'b1;
    wait_change(lat, 20);
    check("down_on_tick_latency", lat, 7);
    btn_down = 1'b0;
    wait_change(lat, 20);
    check("tick_after_drop", lat, 8);
    auto_en = 1'b0;
    cycles(20);
    check("auto_off_num", int'(num), 1);

    // Reach 9, then reset mid PRESS_WAIT with the button held
    for (int i = 2; i <= 9; i++) press_btn(0, 5'(i));
    check("pre_reset_num", int'(num), 9);
    btn_up = 1'b1;
    cycles(4);
    reset = 1'b1;
    cycles(1);
    check("mid_reset_num", int'(num), 0);
    check("mid_reset_changed", int'(num_changed), 0);
    reset = 1'b0;
    exp_q.push_back(5'd1);
    wait_change(lat, 20);
    check("post_reset_latency", lat, 7);
    btn_up = 1'b0;
    cycles(10);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
